// File: rtl/ccx2max.sv
// ccx2max: bridges SPARC CCX request/return ports to 32-bit Maxeler streams.
module ccx2max #(
  parameter int PCX_WIDTH      = 124,
  parameter int CPX_WIDTH      = 145,
  parameter int MAX_D_WIDTH    = 32,
  parameter int PCX_FIFO_DEPTH = 16
) (
  input  logic                   gclk,
  input  logic                   reset,
  input  logic [4:0]             spc_pcx_req_pq,
  input  logic                   spc_pcx_atom_pq,
  input  logic [PCX_WIDTH-1:0]   spc_pcx_data_pa,
  output logic [4:0]             pcx_spc_grant_px,
  output logic                   cpx_spc_data_rdy_cx2,
  output logic [CPX_WIDTH-1:0]   cpx_spc_data_cx2,
  output logic [MAX_D_WIDTH-1:0] max_pcx_data,
  input  logic                   max_pcx_read,
  output logic                   max_pcx_empty,
  output logic                   max_pcx_almost_empty,
  input  logic                   max_cpx_valid,
  input  logic [MAX_D_WIDTH-1:0] max_cpx_data,
  output logic                   max_cpx_stall,
  input  logic                   max_cpx_ctl_valid,
  input  logic [MAX_D_WIDTH-1:0] max_cpx_ctl_data,
  output logic                   max_cpx_ctl_stall
);
  localparam int AW = $clog2(PCX_FIFO_DEPTH);
  typedef enum logic [1:0] {S_W0, S_W1, S_W2, S_W3} st_t;
  logic [4:0] req_q, req_d;
  logic atom_q, atom_d, cap_q, cap_d;
  logic [PCX_WIDTH-1:0] sdat_q [2];
  logic [PCX_WIDTH-1:0] sdat_d [2];
  logic [4:0] sreq_q [2];
  logic [4:0] sreq_d [2];
  logic [1:0] satm_q, satm_d, scnt_q, scnt_d;
  logic swp_q, swp_d, srp_q, srp_d;
  st_t st_q, st_d;
  logic go, wr, pop, push, rd;
  logic [PCX_WIDTH-1:0] head;
  logic [MAX_D_WIDTH-1:0] wdat;
  logic [4:0] grant_q, grant_d;
  logic [MAX_D_WIDTH-1:0] mem_q [PCX_FIFO_DEPTH];
  logic [MAX_D_WIDTH-1:0] mem_d [PCX_FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [4:0] mask_q, mask_d, mbase, slot;
  logic [CPX_WIDTH-1:0] asm_q, asm_d, held_q, held_d, out_q, out_d;
  logic afl_q, afl_d, hv_q, hv_d, cmp_q, cmp_d, sec_q, sec_d, rdy_q, rdy_d;
  logic acc, done;
  logic [2:0] idx;
  logic unused;
  assign unused = &{1'b0, max_cpx_ctl_data[MAX_D_WIDTH-1:4], max_cpx_data[MAX_D_WIDTH-1:18]};
  // Request capture: data arrives the cycle after req, into a 2-deep staging buffer
  always_comb begin
    req_d  = spc_pcx_req_pq;
    atom_d = spc_pcx_atom_pq;
    cap_d  = |spc_pcx_req_pq;
    pop    = st_q == S_W3;
    push   = cap_q && (scnt_q != 2'd2 || pop);
    sdat_d = sdat_q;
    sreq_d = sreq_q;
    satm_d = satm_q;
    if (push) begin
      sdat_d[swp_q] = spc_pcx_data_pa;
      sreq_d[swp_q] = req_q;
      satm_d[swp_q] = atom_q;
    end
    swp_d  = swp_q ^ push;
    srp_d  = srp_q ^ pop;
    scnt_d = scnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge gclk)
    if (reset) st_q <= S_W0;
    else st_q <= st_d;
  always_comb begin
    go   = scnt_q != 2'd0 && ((AW+1)'(PCX_FIFO_DEPTH) - cnt_q) >= (AW+1)'(4);
    st_d = st_q == S_W0 ? (go ? S_W1 : S_W0) : st_t'(st_q + 2'd1);
  end
  // Word 0 goes out in the same cycle the transfer is launched
  always_comb begin
    head    = sdat_q[srp_q];
    wr      = st_q != S_W0 || go;
    wdat    = st_q == S_W0 ? {satm_q[srp_q], 3'b000, head[123:96]} :
              st_q == S_W1 ? head[95:64] :
              st_q == S_W2 ? head[63:32] : head[31:0];
    grant_d = pop ? sreq_q[srp_q] : 5'b0;
  end
  always_comb begin
    rd    = max_pcx_read && cnt_q != '0;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = wdat;
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  assign max_pcx_data         = cnt_q == '0 ? '0 : mem_q[rp_q];
  assign max_pcx_empty        = cnt_q == '0;
  assign max_pcx_almost_empty = cnt_q <= (AW+1)'(1);
  assign pcx_spc_grant_px     = grant_q;
  // Return assembly: data and control words are consumed together
  always_comb begin
    idx   = max_cpx_ctl_data[2:0];
    acc   = max_cpx_valid && max_cpx_ctl_valid && !max_cpx_stall;
    slot  = idx < 3'd5 ? 5'b00001 << idx : 5'b0;
    mbase = max_cpx_ctl_data[3] ? 5'b0 : mask_q;
    asm_d = asm_q;
    if (acc && idx == 3'd0) asm_d[144:128] = max_cpx_data[16:0];
    if (acc && idx == 3'd1) asm_d[127:96] = max_cpx_data;
    if (acc && idx == 3'd2) asm_d[95:64] = max_cpx_data;
    if (acc && idx == 3'd3) asm_d[63:32] = max_cpx_data;
    if (acc && idx == 3'd4) asm_d[31:0] = max_cpx_data;
    afl_d  = (acc && idx == 3'd0) ? max_cpx_data[17] : afl_q;
    done   = acc && (mbase | slot) == 5'h1f;
    mask_d = done ? 5'b0 : acc ? (mbase | slot) : mask_q;
  end
  // An atomic packet waits in held_q until its partner completes, then both go out back to back
  always_comb begin
    rdy_d  = 1'b0;
    out_d  = out_q;
    cmp_d  = 1'b0;
    sec_d  = 1'b0;
    hv_d   = hv_q;
    held_d = held_q;
    if (sec_q) begin
      out_d = held_q;
      rdy_d = 1'b1;
      hv_d  = 1'b0;
    end
    if (done) begin
      cmp_d = 1'b1;
      if (hv_q) begin
        out_d  = held_q;
        rdy_d  = 1'b1;
        held_d = asm_d;
        sec_d  = 1'b1;
      end else if (afl_d) begin
        held_d = asm_d;
        hv_d   = 1'b1;
      end else begin
        out_d = asm_d;
        rdy_d = 1'b1;
      end
    end
  end
  assign max_cpx_stall        = cmp_q | sec_q;
  assign max_cpx_ctl_stall    = cmp_q | sec_q;
  assign cpx_spc_data_rdy_cx2 = rdy_q;
  assign cpx_spc_data_cx2     = out_q;
  always_ff @(posedge gclk)
    if (reset) begin
      req_q   <= '0;
      atom_q  <= 1'b0;
      cap_q   <= 1'b0;
      sdat_q  <= '{default: '0};
      sreq_q  <= '{default: '0};
      satm_q  <= '0;
      scnt_q  <= '0;
      swp_q   <= 1'b0;
      srp_q   <= 1'b0;
      grant_q <= '0;
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      asm_q   <= '0;
      held_q  <= '0;
      out_q   <= '0;
      afl_q   <= 1'b0;
      hv_q    <= 1'b0;
      cmp_q   <= 1'b0;
      sec_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      atom_q  <= atom_d;
      cap_q   <= cap_d;
      sdat_q  <= sdat_d;
      sreq_q  <= sreq_d;
      satm_q  <= satm_d;
      scnt_q  <= scnt_d;
      swp_q   <= swp_d;
      srp_q   <= srp_d;
      grant_q <= grant_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      asm_q   <= asm_d;
      held_q  <= held_d;
      out_q   <= out_d;
      afl_q   <= afl_d;
      hv_q    <= hv_d;
      cmp_q   <= cmp_d;
      sec_q   <= sec_d;
      rdy_q   <= rdy_d;
    end
endmodule

// File: tb/tb_ccx2max.sv
// tb_ccx2max: scoreboard bench for the CCX to Maxeler bridge.
module tb_ccx2max;
  logic gclk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] spc_pcx_req_pq, pcx_spc_grant_px;
  logic spc_pcx_atom_pq, cpx_spc_data_rdy_cx2, max_pcx_read, max_pcx_empty, max_pcx_almost_empty;
  logic [123:0] spc_pcx_data_pa;
  logic [144:0] cpx_spc_data_cx2;
  logic [31:0] max_pcx_data, max_cpx_data, max_cpx_ctl_data;
  logic max_cpx_valid, max_cpx_stall, max_cpx_ctl_valid, max_cpx_ctl_stall;
  typedef struct {logic [4:0] g; int c;} gexp_t;
  logic [31:0] wq[$];
  gexp_t gq[$];
  logic [144:0] pq[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rdy_cnt = 0;
  int last_rdy = -10;
  int prev_rdy = -10;
  int r0;
  ccx2max dut (
    .gclk(gclk), .reset(reset),
    .spc_pcx_req_pq(spc_pcx_req_pq), .spc_pcx_atom_pq(spc_pcx_atom_pq),
    .spc_pcx_data_pa(spc_pcx_data_pa), .pcx_spc_grant_px(pcx_spc_grant_px),
    .cpx_spc_data_rdy_cx2(cpx_spc_data_rdy_cx2), .cpx_spc_data_cx2(cpx_spc_data_cx2),
    .max_pcx_data(max_pcx_data), .max_pcx_read(max_pcx_read),
    .max_pcx_empty(max_pcx_empty), .max_pcx_almost_empty(max_pcx_almost_empty),
    .max_cpx_valid(max_cpx_valid), .max_cpx_data(max_cpx_data), .max_cpx_stall(max_cpx_stall),
    .max_cpx_ctl_valid(max_cpx_ctl_valid), .max_cpx_ctl_data(max_cpx_ctl_data),
    .max_cpx_ctl_stall(max_cpx_ctl_stall)
  );
  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge gclk) begin
    gexp_t e;
    if (!reset) begin
      if (pcx_spc_grant_px != 5'b0) begin
        if (gq.size() == 0) chk("unexpected grant", pcx_spc_grant_px, 0);
        else begin
          e = gq.pop_front();
          chk("grant", pcx_spc_grant_px, e.g);
          if (e.c >= 0) chk("grant cycle", cyc, e.c);
        end
      end
      if (max_pcx_read) begin
        if (wq.size() == 0) chk("pcx word extra", max_pcx_data, 0);
        else chk("pcx word", max_pcx_data, wq.pop_front());
      end
      if (cpx_spc_data_rdy_cx2) begin
        rdy_cnt++;
        prev_rdy = last_rdy;
        last_rdy = cyc;
        if (pq.size() == 0) chk("cpx extra packet", cpx_spc_data_cx2, 0);
        else chk("cpx packet", cpx_spc_data_cx2, pq.pop_front());
      end
    end
  end
  task automatic send_pcx(input logic [4:0] r, input logic a, input logic [123:0] d, input bit timed);
    gexp_t e;
    @(posedge gclk); #1;
    spc_pcx_req_pq = r;
    spc_pcx_atom_pq = a;
    wq.push_back({a, 3'b000, d[123:96]});
    wq.push_back(d[95:64]);
    wq.push_back(d[63:32]);
    wq.push_back(d[31:0]);
    e.g = r;
    e.c = timed ? cyc + 6 : -1;
    gq.push_back(e);
    @(posedge gclk); #1;
    spc_pcx_req_pq = 5'b0;
    spc_pcx_atom_pq = 1'b0;
    spc_pcx_data_pa = d;
    @(posedge gclk); #1;
    spc_pcx_data_pa = '0;
  endtask
  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge gclk); #1;
      max_pcx_read = 1'b1;
    end
    @(posedge gclk); #1;
    max_pcx_read = 1'b0;
  endtask
  task automatic wait_grants(input int lim);
    int n = 0;
    while (gq.size() != 0 && n < lim) begin
      @(posedge gclk);
      n++;
    end
    chk("grant wait", gq.size(), 0);
  endtask
  task automatic wait_pkts(input int lim);
    int n = 0;
    while (pq.size() != 0 && n < lim) begin
      @(posedge gclk);
      n++;
    end
    chk("cpx packet wait", pq.size(), 0);
  endtask
  task automatic cpx_word(input logic [31:0] d, input logic [31:0] c);
    int n = 0;
    max_cpx_valid = 1'b1;
    max_cpx_ctl_valid = 1'b1;
    max_cpx_data = d;
    max_cpx_ctl_data = c;
    @(negedge gclk);
    while (max_cpx_stall && n < 10) begin
      @(negedge gclk);
      n++;
    end
    if (n == 10) chk("cpx stall stuck", max_cpx_stall, 0);
    @(posedge gclk); #1;
    max_cpx_valid = 1'b0;
    max_cpx_ctl_valid = 1'b0;
  endtask
  task automatic cpx_pkt(input logic [31:0] w0, w1, w2, w3, w4);
    pq.push_back({w0[16:0], w1, w2, w3, w4});
    cpx_word(w0, 32'h8);
    cpx_word(w1, 32'h1);
    cpx_word(w2, 32'h2);
    cpx_word(w3, 32'h3);
    cpx_word(w4, 32'h4);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] u;
    spc_pcx_req_pq = '0; spc_pcx_atom_pq = 1'b0; spc_pcx_data_pa = '0; max_pcx_read = 1'b0;
    max_cpx_valid = 1'b0; max_cpx_data = '0; max_cpx_ctl_valid = 1'b0; max_cpx_ctl_data = '0;
    repeat (2) @(posedge gclk);
    #1 reset = 1'b0;
    @(negedge gclk);
    chk("reset grant", pcx_spc_grant_px, 0);
    chk("reset data_rdy", cpx_spc_data_rdy_cx2, 0);
    chk("reset cpx data", cpx_spc_data_cx2, 0);
    chk("reset empty", max_pcx_empty, 1);
    chk("reset almost_empty", max_pcx_almost_empty, 1);
    chk("reset stall", max_cpx_stall, 0);
    chk("reset ctl_stall", max_cpx_ctl_stall, 0);
    chk("reset pcx data", max_pcx_data, 0);
    send_pcx(5'b00001, 1'b0, {28'hDEAD111, 32'h1A1B1C1D, 32'h2A1B1C1D, 32'h3A1B1C1D}, 1'b1);
    wait_grants(20);
    @(negedge gclk);
    chk("single empty", max_pcx_empty, 0);
    chk("single almost_empty", max_pcx_almost_empty, 0);
    chk("single head", max_pcx_data, 32'h0DEAD111);
    for (int i = 0; i < 4; i++) begin
      @(posedge gclk); #1 max_pcx_read = 1'b1;
      @(posedge gclk); #1 max_pcx_read = 1'b0;
      @(negedge gclk);
      chk("drain empty", max_pcx_empty, i == 3);
      chk("drain almost_empty", max_pcx_almost_empty, i >= 2);
    end
    for (int k = 0; k < 4; k++) begin
      send_pcx(5'(1 << k), 1'b0, {28'hDEAD111 + 28'(k) * 28'h111, 32'h1A1B1C1D + 32'(k),
               32'h2A1B1C1D + 32'(k), 32'h3A1B1C1D + 32'(k)}, 1'b1);
      repeat (13) @(posedge gclk);
    end
    wait_grants(20);
    @(negedge gclk);
    chk("full almost_empty", max_pcx_almost_empty, 0);
    send_pcx(5'b10000, 1'b1, {28'hDEAD555, 32'h5A5B5C5D, 32'h6A6B6C6D, 32'h7A7B7C7D}, 1'b0);
    repeat (20) @(posedge gclk);
    chk("fifth not granted while full", gq.size(), 1);
    read_words(20);
    wait_grants(30);
    @(negedge gclk);
    chk("all words read", wq.size(), 0);
    chk("empty after drain", max_pcx_empty, 1);
    for (int k = 1; k <= 3; k++) begin
      u = 32'(k) << 16;
      cpx_pkt(u, u + 1, u + 2, u + 3, u + 4);
    end
    wait_pkts(30);
    chk("three packets", rdy_cnt, 3);
    r0 = rdy_cnt;
    cpx_pkt(32'h00021111, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
    repeat (5) @(posedge gclk);
    chk("atomic held", rdy_cnt, r0);
    cpx_pkt(32'h00002222, 32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004);
    wait_pkts(20);
    @(negedge gclk);
    chk("atomic pair count", rdy_cnt, r0 + 2);
    chk("atomic pair consecutive", last_rdy - prev_rdy, 1);
    r0 = rdy_cnt;
    cpx_word(32'h00040000, 32'h8);
    cpx_word(32'h00040001, 32'h1);
    cpx_word(32'h00040002, 32'h2);
    @(posedge gclk); #1 reset = 1'b1;
    repeat (2) @(posedge gclk);
    #1 reset = 1'b0;
    repeat (3) @(posedge gclk);
    chk("no packet after abort", rdy_cnt, r0);
    chk("stall after abort", max_cpx_stall, 0);
    pq.push_back({17'h10000, 32'h00050001, 32'h00050002, 32'h00050003, 32'h00050004});
    cpx_word(32'h00050000, 32'h8);
    cpx_word(32'h00050001, 32'h1);
    cpx_word(32'h00050002, 32'h2);
    cpx_word(32'hFFFFFFFF, 32'hFFFFFFF5);
    cpx_word(32'h00050003, 32'h3);
    cpx_word(32'h00050004, 32'h4);
    wait_pkts(20);
    @(negedge gclk);
    chk("recovered packet count", rdy_cnt, r0 + 1);
    chk("grant queue drained", gq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
